control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port instr, input, 16 bits: current instruction register contents; opcode = instr[15:12].
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag, valid in EXEC.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write this cycle.
REQ-006 SHALL have port alu_control, output, 4 bits: ALU function select.
REQ-007 SHALL have port alu_src_b, output, 1 bit: ALU operand-2 select; 0 = register, 1 = sign-extended immediate.
REQ-008 SHALL have ports ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg, each output, 1 bit: datapath enables.
REQ-009 SHALL have port pc_src, output, 2 bits: 00 = PC+1, 01 = branch target, 10 = jump target.
REQ-010 SHALL have port illegal, output, 1 bit: one-cycle pulse on an undefined opcode.
REQ-011 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-012 SHALL have port state, output, 3 bits: state encoding, for debug.

Function
REQ-013 States SHALL be encoded as FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=101; codes 110 and 111 SHALL go to FETCH on the next edge.
REQ-014 Every output not named as asserted in a given state SHALL be 0, and alu_control SHALL be 0000.
REQ-015 FETCH: mem_read=1; while mem_ready=0, stay in FETCH.
REQ-016 FETCH with mem_ready=1: ir_write=1, pc_write=1, pc_src=00 in that same cycle (Mealy), then go to DECODE.
REQ-017 DECODE: latch instr[15:12] into an internal opcode register; go to EXEC after 1 cycle.
REQ-018 EXEC and later states SHALL decode only the latched opcode; changes on instr after DECODE SHALL have no effect.
REQ-019 EXEC, opcodes 0000-1000: alu_control=opcode, alu_src_b=0; go to WB.
REQ-020 EXEC, opcodes 1001 (LOAD) and 1010 (STORE): alu_control=0000, alu_src_b=1; go to MEM.
REQ-021 EXEC, opcode 1011 (BEQ): alu_control=0001, pc_src=01, pc_write=zero; go to FETCH.
REQ-022 EXEC, opcode 1100 (BNE): alu_control=0001, pc_src=01, pc_write=~zero; go to FETCH.
REQ-023 EXEC, opcode 1101 (JMP): pc_write=1, pc_src=10; go to FETCH.
REQ-024 EXEC, opcode 1110: illegal=1 for one cycle, no enables asserted; go to FETCH.
REQ-025 EXEC, opcode 1111 (HALT): go to HALT.
REQ-026 MEM, LOAD: mem_read=1 until mem_ready, then go to WB.
REQ-027 MEM, STORE: mem_write=1 until mem_ready, then go to FETCH.
REQ-028 In every stall cycle (mem_ready=0), no other enable SHALL be asserted.
REQ-029 WB: reg_write=1; mem_to_reg=1 only for LOAD; go to FETCH.
REQ-030 HALT: halted=1 and all enables 0; leave HALT only by reset.
REQ-031 Latency with mem_ready held at 1 SHALL be: ALU op 4 cycles, LOAD 5, STORE 4, BEQ/BNE/JMP/illegal 3.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force state=FETCH and opcode register=0000.
REQ-033 While rst_n=0, every output SHALL be 0, including mem_read, illegal and halted.
REQ-034 Reset asserted in any state, including mid-stall and HALT, SHALL abort the operation with no further enables asserted.
REQ-035 The first rising edge after rst_n rises SHALL evaluate FETCH normally.

Verification
REQ-036 Reset, then instr=16'h0123 (ADD) with mem_ready=1 -> states FETCH, DECODE, EXEC, WB; alu_control=0000 in EXEC; reg_write=1 only in WB.
REQ-037 LOAD (16'h9xxx) with mem_ready=0 for 3 cycles in MEM -> MEM held 4 cycles with mem_read=1; then WB with reg_write=1 and mem_to_reg=1.
REQ-038 BEQ with zero=1 -> pc_write=1 and pc_src=01 in EXEC; BEQ with zero=0 -> pc_write=0; BNE gives the inverse.
REQ-039 Opcode 1110 -> illegal high exactly 1 cycle in EXEC, then FETCH; opcode 1111 -> halted=1 held for 20 cycles until rst_n pulse.
REQ-040 rst_n driven low between clock edges during a MEM stall of a STORE -> state=000 and mem_write=0 immediately; no write after release.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// for a 16-bit instruction set and drives the datapath enables.
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_control,
  output logic        alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
  localparam logic [2:0] S_HALT   = 3'b101;

  localparam logic [3:0] OP_LOAD  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1101;
  localparam logic [3:0] OP_ILL   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic [ALU_W-1:0]   alu_control_c;
  logic               alu_src_b_c;
  logic               ir_write_c;
  logic               pc_write_c;
  logic               reg_write_c;
  logic               mem_read_c;
  logic               mem_write_c;
  logic               mem_to_reg_c;
  logic [PCSRC_W-1:0] pc_src_c;
  logic               illegal_c;
  logic               halted_c;

  // Only the opcode field is decoded; operand fields belong to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[11:0];

  // State and latched-opcode registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and control decode; later states only look at the latched opcode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    alu_control_c = ALU_ADD;
    alu_src_b_c   = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    mem_to_reg_c  = 1'b0;
    pc_src_c      = PC_SEQ;
    illegal_c     = 1'b0;
    halted_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = PC_SEQ;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = instr[15:12];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
          4'b0101, 4'b0110, 4'b0111, 4'b1000: begin
            alu_control_c = ALU_W'(op_q);
            state_d       = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_c = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            alu_control_c = ALU_SUB;
            pc_src_c      = PC_BR;
            pc_write_c    = zero;
            state_d       = S_FETCH;
          end
          OP_BNE: begin
            alu_control_c = ALU_SUB;
            pc_src_c      = PC_BR;
            pc_write_c    = ~zero;
            state_d       = S_FETCH;
          end
          OP_JMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = PC_JMP;
            state_d    = S_FETCH;
          end
          OP_ILL: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
          OP_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LOAD) begin
          mem_read_c = 1'b1;
          if (mem_ready) begin
            state_d = S_WB;
          end
        end else begin
          mem_write_c = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (op_q == OP_LOAD);
        state_d      = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign alu_control = rst_n ? alu_control_c : '0;
  assign pc_src      = rst_n ? pc_src_c : '0;
  assign alu_src_b   = rst_n & alu_src_b_c;
  assign ir_write    = rst_n & ir_write_c;
  assign pc_write    = rst_n & pc_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign mem_read    = rst_n & mem_read_c;
  assign mem_write   = rst_n & mem_write_c;
  assign mem_to_reg  = rst_n & mem_to_reg_c;
  assign illegal     = rst_n & illegal_c;
  assign halted      = rst_n & halted_c;
  assign state       = state_q;

endmodule
